// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared pipeline types. word_t is the machine word. The fetch-stage
// additions are:
//   fetch_state_t : fetch sequencer state (RUN, HALTED)
//   PC_INIT_DEF   : default PC after reset
//   NOP_WORD      : instruction shown to decode when IF/ID is empty
//   ifid_t        : contents of the IF/ID pipeline latch
//   pc_plus4      : sequential PC increment with 32-bit wrap
// ---------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   localparam word_t PC_INIT_DEF = 32'h0000_0000;
   localparam word_t NOP_WORD    = 32'h0000_0000;

   typedef struct packed {
      word_t instru;
      word_t nPC;
      logic  valid;
   } ifid_t;

   // Wraps naturally: 0xFFFF_FFFC + 4 = 0.
   function automatic word_t pc_plus4(input word_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// IF/ID handoff bundle between fetch and decode.
//   ifid : latch contents {instru, nPC, valid}
// Modports:
//   fe : fetch side, drives the latch contents
//   de : decode side, consumes them
// ---------------------------------------------------------------------------
interface fetch_if;
   import cpu_types_pkg::*;

   ifid_t ifid;

   modport fe (output ifid);
   modport de (input  ifid);
endinterface

// File: rtl/fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// fetch_hold_buf
// One-entry {instr, nPC} buffer. It parks a word that the icache returned
// while IF/ID was stalled, so the word is neither lost nor refetched.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   capture     : store instr_in/npc_in (ignored while already full)
//   release_en  : entry consumed by the IF/ID latch
//   clear       : drop the entry; overrides capture and release
//   instr_in    : word to capture
//   npc_in      : matching PC+4 to capture
//   hold_valid  : entry is occupied
//   hold_instr  : stored word
//   hold_npc    : stored PC+4
// ---------------------------------------------------------------------------
module fetch_hold_buf
   import cpu_types_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  capture,
   input  logic  release_en,
   input  logic  clear,
   input  word_t instr_in,
   input  word_t npc_in,
   output logic  hold_valid,
   output word_t hold_instr,
   output word_t hold_npc
);

   logic  valid_reg;
   word_t instr_reg;
   word_t npc_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         instr_reg <= '0;
         npc_reg   <= '0;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end else if (capture && !valid_reg) begin
         valid_reg <= 1'b1;
         instr_reg <= instr_in;
         npc_reg   <= npc_in;
      end else if (release_en) begin
         valid_reg <= 1'b0;
      end
   end

   assign hold_valid = valid_reg;
   assign hold_instr = instr_reg;
   assign hold_npc   = npc_reg;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch plus the IF/ID pipeline latch. It owns the PC, issues
// icache requests and presents {instru, nPC, valid} to decode.
// Ports:
//   CLK, RST    : clock, asynchronous active-high reset
//   ihit, iload : icache returned iload for imemaddr this cycle
//   imemREN     : fetch request
//   imemaddr    : fetch address (the PC)
//   stall       : freeze the IF/ID latch
//   flush       : squash the IF/ID latch and the hold buffer
//   redirect    : take redirect_pc as the next PC
//   redirect_pc : redirect target; bits [1:0] are ignored
//   halt        : stop fetching until reset
//   instru, nPC : IF/ID instruction and PC+4
//   valid       : IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT  = PC_INIT_DEF,
   parameter word_t NOP_WORD = cpu_types_pkg::NOP_WORD
)(
   input  logic  CLK,
   input  logic  RST,
   input  logic  ihit,
   input  word_t iload,
   output logic  imemREN,
   output word_t imemaddr,
   input  logic  stall,
   input  logic  flush,
   input  logic  redirect,
   input  word_t redirect_pc,
   input  logic  halt,
   output word_t instru,
   output word_t nPC,
   output logic  valid
);

   fetch_state_t state_reg, state_next;
   word_t        pc_reg, pc_next;
   ifid_t        ifid_reg, ifid_next;

   logic  hold_valid;
   word_t hold_instr;
   word_t hold_npc;

   logic  running;
   logic  acc;
   logic  kill;
   word_t pc_inc;
   word_t redirect_target;
   logic  redirect_lsb_unused;

   assign running  = (state_reg == RUN);
   // No request while the hold buffer is full, so it can never be overrun.
   assign imemREN  = running && !hold_valid;
   assign imemaddr = pc_reg;
   assign acc      = ihit && imemREN;
   // Anything that invalidates the in-flight / latched instruction.
   assign kill     = flush || redirect || halt || !running;
   assign pc_inc   = pc_plus4(pc_reg);

   assign redirect_target     = {redirect_pc[31:2], 2'b00};
   assign redirect_lsb_unused = |redirect_pc[1:0];

   fetch_hold_buf u_hold (
      .clk        (CLK),
      .rst        (RST),
      .capture    (acc && stall),
      .release_en (hold_valid && !stall),
      .clear      (kill),
      .instr_in   (iload),
      .npc_in     (pc_inc),
      .hold_valid (hold_valid),
      .hold_instr (hold_instr),
      .hold_npc   (hold_npc)
   );

   always_comb begin
      state_next = state_reg;
      if (running && halt)
         state_next = HALTED;
   end

   always_comb begin
      pc_next = pc_reg;
      if (running && !halt) begin
         if (redirect)
            pc_next = redirect_target;
         else if (acc)
            pc_next = pc_inc;
      end
   end

   always_comb begin
      ifid_next = '{instru: NOP_WORD, nPC: '0, valid: 1'b0};
      if (kill)
         ifid_next = '{instru: NOP_WORD, nPC: '0, valid: 1'b0};
      else if (stall)
         ifid_next = ifid_reg;
      else if (hold_valid)
         ifid_next = '{instru: hold_instr, nPC: hold_npc, valid: 1'b1};
      else if (acc)
         ifid_next = '{instru: iload, nPC: pc_inc, valid: 1'b1};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= RUN;
         pc_reg    <= PC_INIT;
         ifid_reg  <= '{instru: NOP_WORD, nPC: '0, valid: 1'b0};
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ifid_reg  <= ifid_next;
      end
   end

   fetch_if u_ifid ();
   assign u_ifid.ifid = ifid_reg;

   assign instru = u_ifid.ifid.instru;
   assign nPC    = u_ifid.ifid.nPC;
   assign valid  = u_ifid.ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] iload;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] instru;
   logic [31:0] nPC;
   logic        valid;

   int tests  = 0;
   int failed = 0;

   fetch_stage dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload),
      .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .instru(instru), .nPC(nPC), .valid(valid)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; ihit = 0; iload = 0; stall = 0; flush = 0;
      redirect = 0; redirect_pc = 0; halt = 0;
      #3;
      tests++; if (imemREN !== 1'b1) begin failed++; $display("FAIL reset_ren: got %b expected 1", imemREN); end
      tests++; if (imemaddr !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h expected 00000000", imemaddr); end
      tests++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", valid); end
      tests++; if (instru !== 32'h0 || nPC !== 32'h0) begin failed++; $display("FAIL reset_latch: got instru=%h nPC=%h expected 0/0", instru, nPC); end
      step();
      RST = 1'b0;
      $display("[TB] reset: addr=%h ren=%b valid=%b", imemaddr, imemREN, valid);
   endtask

   task automatic test_sequential();
      ihit = 1; iload = 32'h2001_0005;
      tests++; if (imemaddr !== 32'h0) begin failed++; $display("FAIL seq_addr0: got %h expected 00000000", imemaddr); end
      step();
      tests++; if (instru !== 32'h2001_0005 || nPC !== 32'h4 || valid !== 1'b1) begin failed++; $display("FAIL seq_first: got %h/%h/%b expected 20010005/00000004/1", instru, nPC, valid); end
      tests++; if (imemaddr !== 32'h4) begin failed++; $display("FAIL seq_addr4: got %h expected 00000004", imemaddr); end
      iload = 32'h2002_0007;
      step();
      tests++; if (instru !== 32'h2002_0007 || nPC !== 32'h8 || valid !== 1'b1) begin failed++; $display("FAIL seq_second: got %h/%h/%b expected 20020007/00000008/1", instru, nPC, valid); end
      tests++; if (imemaddr !== 32'h8) begin failed++; $display("FAIL seq_addr8: got %h expected 00000008", imemaddr); end
      $display("[TB] sequential: addr=%h instru=%h nPC=%h", imemaddr, instru, nPC);
   endtask

   task automatic test_miss();
      ihit = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (imemaddr !== 32'h8 || valid !== 1'b0 || instru !== 32'h0) begin failed++; $display("FAIL miss_bubble%0d: got addr=%h valid=%b instru=%h expected 00000008/0/00000000", i, imemaddr, valid, instru); end
      end
      ihit = 1; iload = 32'h2003_0009;
      step();
      tests++; if (instru !== 32'h2003_0009 || nPC !== 32'hC || valid !== 1'b1) begin failed++; $display("FAIL miss_hit: got %h/%h/%b expected 20030009/0000000c/1", instru, nPC, valid); end
      $display("[TB] miss: addr=%h nPC=%h", imemaddr, nPC);
   endtask

   task automatic test_stall();
      // PC=0xC, latch holds 0x2003_0009
      stall = 1; ihit = 1; iload = 32'h1111_2222;
      step();
      tests++; if (instru !== 32'h2003_0009 || nPC !== 32'hC || valid !== 1'b1) begin failed++; $display("FAIL stall_frozen: got %h/%h/%b expected 20030009/0000000c/1", instru, nPC, valid); end
      tests++; if (imemREN !== 1'b0 || imemaddr !== 32'h10) begin failed++; $display("FAIL stall_ren: got ren=%b addr=%h expected 0/00000010", imemREN, imemaddr); end
      iload = 32'hDEAD_BEEF;
      step();
      tests++; if (instru !== 32'h2003_0009 || imemREN !== 1'b0 || imemaddr !== 32'h10) begin failed++; $display("FAIL stall_second: got instru=%h ren=%b addr=%h expected 20030009/0/00000010", instru, imemREN, imemaddr); end
      stall = 0; ihit = 0;
      step();
      tests++; if (instru !== 32'h1111_2222 || nPC !== 32'h10 || valid !== 1'b1) begin failed++; $display("FAIL stall_release: got %h/%h/%b expected 11112222/00000010/1", instru, nPC, valid); end
      tests++; if (imemREN !== 1'b1 || imemaddr !== 32'h10) begin failed++; $display("FAIL stall_pc_once: got ren=%b addr=%h expected 1/00000010", imemREN, imemaddr); end
      $display("[TB] stall: instru=%h addr=%h", instru, imemaddr);
   endtask

   task automatic test_redirect_flush();
      ihit = 1; iload = 32'hAAAA_0001; redirect = 1; redirect_pc = 32'h0000_0043;
      step();
      tests++; if (imemaddr !== 32'h40 || valid !== 1'b0 || instru !== 32'h0) begin failed++; $display("FAIL redir_hit: got addr=%h valid=%b instru=%h expected 00000040/0/00000000", imemaddr, valid, instru); end
      redirect = 0; stall = 1; iload = 32'hBBBB_0002;
      step();
      tests++; if (imemREN !== 1'b0 || imemaddr !== 32'h44) begin failed++; $display("FAIL redir_capture: got ren=%b addr=%h expected 0/00000044", imemREN, imemaddr); end
      redirect = 1; redirect_pc = 32'h10; stall = 0; ihit = 0;
      step();
      tests++; if (imemREN !== 1'b1 || imemaddr !== 32'h10 || valid !== 1'b0) begin failed++; $display("FAIL redir_clear: got ren=%b addr=%h valid=%b expected 1/00000010/0", imemREN, imemaddr, valid); end
      redirect = 0;
      step();
      tests++; if (valid !== 1'b0 || instru !== 32'h0) begin failed++; $display("FAIL redir_no_release: got valid=%b instru=%h expected 0/00000000", valid, instru); end
      ihit = 1; iload = 32'hCCCC_0003;
      step();
      tests++; if (valid !== 1'b1 || instru !== 32'hCCCC_0003 || nPC !== 32'h14) begin failed++; $display("FAIL flush_setup: got %h/%h/%b expected cccc0003/00000014/1", instru, nPC, valid); end
      ihit = 0; flush = 1; stall = 1;
      step();
      tests++; if (valid !== 1'b0 || instru !== 32'h0) begin failed++; $display("FAIL flush_stall: got valid=%b instru=%h expected 0/00000000", valid, instru); end
      flush = 0; stall = 0;
      $display("[TB] redirect/flush: addr=%h valid=%b", imemaddr, valid);
   endtask

   task automatic test_wrap();
      redirect = 1; redirect_pc = 32'hFFFF_FFFC; ihit = 0;
      step();
      tests++; if (imemaddr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_target: got %h expected fffffffc", imemaddr); end
      redirect = 0; ihit = 1; iload = 32'h1234_5678;
      step();
      tests++; if (imemaddr !== 32'h0 || nPC !== 32'h0 || instru !== 32'h1234_5678 || valid !== 1'b1) begin failed++; $display("FAIL wrap_inc: got addr=%h nPC=%h instru=%h valid=%b expected 0/0/12345678/1", imemaddr, nPC, instru, valid); end
      ihit = 0; redirect = 1; redirect_pc = 32'h10;
      step();
      redirect = 0;
      $display("[TB] wrap: addr=%h", imemaddr);
   endtask

   task automatic test_halt();
      halt = 1; ihit = 1; iload = 32'h5555_5555;
      step();
      tests++; if (imemREN !== 1'b0 || imemaddr !== 32'h10 || valid !== 1'b0) begin failed++; $display("FAIL halt_enter: got ren=%b addr=%h valid=%b expected 0/00000010/0", imemREN, imemaddr, valid); end
      halt = 0; redirect = 1; redirect_pc = 32'h80;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (imemREN !== 1'b0 || imemaddr !== 32'h10 || valid !== 1'b0) begin failed++; $display("FAIL halt_sticky%0d: got ren=%b addr=%h valid=%b expected 0/00000010/0", i, imemREN, imemaddr, valid); end
      end
      redirect = 0; ihit = 0;
      $display("[TB] halt: addr=%h ren=%b", imemaddr, imemREN);
   endtask

   task automatic test_reset_mid();
      #2 RST = 1'b1;
      #1;
      tests++; if (imemREN !== 1'b1 || imemaddr !== 32'h0 || valid !== 1'b0 || instru !== 32'h0 || nPC !== 32'h0) begin failed++; $display("FAIL reset_async: got ren=%b addr=%h valid=%b instru=%h nPC=%h expected 1/0/0/0/0", imemREN, imemaddr, valid, instru, nPC); end
      #1 RST = 1'b0;
      ihit = 1; iload = 32'h7777_0001;
      step();
      tests++; if (instru !== 32'h7777_0001 || nPC !== 32'h4 || valid !== 1'b1 || imemaddr !== 32'h4) begin failed++; $display("FAIL reset_restart: got instru=%h nPC=%h valid=%b addr=%h expected 77770001/4/1/4", instru, nPC, valid, imemaddr); end
      ihit = 0;
      $display("[TB] reset mid-cycle: addr=%h valid=%b", imemaddr, valid);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_miss();
      test_stall();
      test_redirect_flush();
      test_wrap();
      test_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
